// File: rtl/logic_axi4_lite_pkg.sv
// logic_axi4_lite_pkg: AXI4-Lite response/access types and buffer sizing helpers.
package logic_axi4_lite_pkg;
    typedef enum logic [1:0] {RESPONSE_OKAY, RESPONSE_EXOKAY, RESPONSE_SLVERR, RESPONSE_DECERR} response_t;
    typedef logic [2:0] access_t;
    function automatic bit is_valid_depth(int depth);
        return depth == 0 || depth >= 2;
    endfunction
    function automatic int counter_width(int max);
        return $clog2(max + 1);
    endfunction
endpackage

// File: rtl/logic_pkg.sv
// logic_pkg: implementation-target selection shared by the logic_* library.
package logic_pkg;
    typedef enum logic [1:0] {TARGET_GENERIC, TARGET_XILINX, TARGET_INTEL} target_t;
endpackage

// File: rtl/logic_axi4_lite_if.sv
// logic_axi4_lite_if: AXI4-Lite bundle with slave/master views.
interface logic_axi4_lite_if
    import logic_axi4_lite_pkg::*;
#(
    parameter int DATA_BYTES = 4,
    parameter int ADDRESS_WIDTH = 1
);
    logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
    logic [ADDRESS_WIDTH-1:0] awaddr, araddr;
    access_t awprot, arprot;
    logic [DATA_BYTES*8-1:0] wdata, rdata;
    logic [DATA_BYTES-1:0] wstrb;
    response_t bresp, rresp;
    modport slave (
        input awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
        input awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/logic_axi4_lite_buffer_channel.sv
// logic_axi4_lite_buffer_channel: one valid/ready channel, pass-through (DEPTH=0) or FIFO (DEPTH>=2).
module logic_axi4_lite_buffer_channel
    import logic_pkg::*;
    import logic_axi4_lite_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2,
    parameter target_t TARGET = TARGET_GENERIC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_valid,
    output logic             rx_ready,
    input  logic [WIDTH-1:0] rx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [WIDTH-1:0] tx_data
);
    if (!is_valid_depth(DEPTH) || TARGET > TARGET_INTEL) begin : g_bad_config
        $error("logic_axi4_lite_buffer_channel: DEPTH must be 0 or >= 2 (got %0d)", DEPTH);
    end
    if (DEPTH == 0) begin : g_pass
        // No handshake may complete while the block is held in reset.
        assign tx_valid = rx_valid && !rst;
        assign rx_ready = tx_ready && !rst;
        assign tx_data  = rx_data;
    end else begin : g_fifo
        localparam int PW = $clog2(DEPTH);
        localparam int CW = $clog2(DEPTH + 1);
        logic [WIDTH-1:0] mem [DEPTH];
        logic [PW-1:0] wr_ptr, rd_ptr;
        logic [CW-1:0] count;
        logic push, pop;
        assign rx_ready = !rst && count != CW'(DEPTH);
        assign tx_valid = count != '0;
        assign tx_data  = mem[rd_ptr];
        assign push = rx_valid && rx_ready;
        assign pop  = tx_valid && tx_ready;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
                if (pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
        always_ff @(posedge clk) begin
            if (push) mem[wr_ptr] <= rx_data;
        end
    end
endmodule

// File: rtl/logic_axi4_lite_buffer.sv
// logic_axi4_lite_buffer: per-channel AXI4-Lite buffering with outstanding write/read limiters.
// Define LOGIC_AXI4_LITE_BUFFER_STATUS_EN to expose the counts and a sticky protocol_error flag.
module logic_axi4_lite_buffer
    import logic_pkg::*;
    import logic_axi4_lite_pkg::*;
#(
    parameter target_t TARGET = TARGET_GENERIC,
    parameter int DATA_BYTES = 4,
    parameter int ADDRESS_WIDTH = 1,
    parameter int AW_DEPTH = 2,
    parameter int W_DEPTH = 2,
    parameter int B_DEPTH = 2,
    parameter int AR_DEPTH = 2,
    parameter int R_DEPTH = 2,
    parameter int MAX_WRITES = 4,
    parameter int MAX_READS = 4
) (
    input logic aclk,
    input logic areset,
    logic_axi4_lite_if.slave slave,
    logic_axi4_lite_if.master master
`ifdef LOGIC_AXI4_LITE_BUFFER_STATUS_EN
    ,
    output logic [counter_width(MAX_WRITES)-1:0] write_outstanding,
    output logic [counter_width(MAX_READS)-1:0]  read_outstanding,
    output logic                                 protocol_error
`endif
);
    localparam int WCW = counter_width(MAX_WRITES);
    localparam int RCW = counter_width(MAX_READS);
    localparam int AXW = ADDRESS_WIDTH + 3;
    localparam int WW = DATA_BYTES * 9;
    localparam int RW = DATA_BYTES * 8 + 2;

    logic [1:0] rst_q;
    logic rst;
    logic [WCW-1:0] wcnt;
    logic [RCW-1:0] rcnt;
    logic aw_ok, ar_ok, aw_rdy, ar_rdy, aw_hs, b_hs, ar_hs, r_hs;
    logic [AXW-1:0] aw_out, ar_out;
    logic [WW-1:0] w_out;
    logic [1:0] b_out;
    logic [RW-1:0] r_out;

    // Reset asserts immediately and is released two aclk edges after areset drops.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) rst_q <= 2'b11;
        else rst_q <= {rst_q[0], 1'b0};
    end
    assign rst = rst_q[1];

    assign aw_ok = wcnt < WCW'(MAX_WRITES);
    assign ar_ok = rcnt < RCW'(MAX_READS);
    assign slave.awready = aw_rdy && aw_ok;
    assign slave.arready = ar_rdy && ar_ok;
    assign aw_hs = slave.awvalid && slave.awready;
    assign b_hs  = slave.bvalid && slave.bready;
    assign ar_hs = slave.arvalid && slave.arready;
    assign r_hs  = slave.rvalid && slave.rready;

    logic_axi4_lite_buffer_channel #(.WIDTH(AXW), .DEPTH(AW_DEPTH), .TARGET(TARGET)) u_aw (
        .clk(aclk), .rst, .rx_valid(slave.awvalid && aw_ok), .rx_ready(aw_rdy),
        .rx_data({slave.awprot, slave.awaddr}), .tx_valid(master.awvalid), .tx_ready(master.awready), .tx_data(aw_out)
    );
    assign {master.awprot, master.awaddr} = aw_out;

    logic_axi4_lite_buffer_channel #(.WIDTH(WW), .DEPTH(W_DEPTH), .TARGET(TARGET)) u_w (
        .clk(aclk), .rst, .rx_valid(slave.wvalid), .rx_ready(slave.wready),
        .rx_data({slave.wstrb, slave.wdata}), .tx_valid(master.wvalid), .tx_ready(master.wready), .tx_data(w_out)
    );
    assign {master.wstrb, master.wdata} = w_out;

    logic_axi4_lite_buffer_channel #(.WIDTH(2), .DEPTH(B_DEPTH), .TARGET(TARGET)) u_b (
        .clk(aclk), .rst, .rx_valid(master.bvalid), .rx_ready(master.bready),
        .rx_data(master.bresp), .tx_valid(slave.bvalid), .tx_ready(slave.bready), .tx_data(b_out)
    );
    assign slave.bresp = response_t'(b_out);

    logic_axi4_lite_buffer_channel #(.WIDTH(AXW), .DEPTH(AR_DEPTH), .TARGET(TARGET)) u_ar (
        .clk(aclk), .rst, .rx_valid(slave.arvalid && ar_ok), .rx_ready(ar_rdy),
        .rx_data({slave.arprot, slave.araddr}), .tx_valid(master.arvalid), .tx_ready(master.arready), .tx_data(ar_out)
    );
    assign {master.arprot, master.araddr} = ar_out;

    logic_axi4_lite_buffer_channel #(.WIDTH(RW), .DEPTH(R_DEPTH), .TARGET(TARGET)) u_r (
        .clk(aclk), .rst, .rx_valid(master.rvalid), .rx_ready(master.rready),
        .rx_data({master.rresp, master.rdata}), .tx_valid(slave.rvalid), .tx_ready(slave.rready), .tx_data(r_out)
    );
    assign slave.rresp = response_t'(r_out[RW-1 -: 2]);
    assign slave.rdata = r_out[RW-3:0];

    // Responses arriving with nothing outstanding leave the count at zero.
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            wcnt <= '0;
            rcnt <= '0;
        end else begin
            if (aw_hs && !b_hs) wcnt <= wcnt + 1'b1;
            else if (b_hs && !aw_hs && wcnt != '0) wcnt <= wcnt - 1'b1;
            if (ar_hs && !r_hs) rcnt <= rcnt + 1'b1;
            else if (r_hs && !ar_hs && rcnt != '0) rcnt <= rcnt - 1'b1;
        end
    end

`ifdef LOGIC_AXI4_LITE_BUFFER_STATUS_EN
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) protocol_error <= 1'b0;
        else if ((b_hs && wcnt == '0) || (r_hs && rcnt == '0)) protocol_error <= 1'b1;
    end
    assign write_outstanding = wcnt;
    assign read_outstanding  = rcnt;
`endif
endmodule
